if_id_hazard_unit: RTL and testbench

IF/ID pipeline register combined with load-use hazard detection and branch flush control for the 5-stage RISC-V core. Sits between instruction fetch and decode. Captures PC and instruction, decodes register fields for the ID/EX register, and drives `ctr_sel` (bubble insert) and `pc_write_en` (PC hold). Also keeps saturating stall and flush event counters.

---
 rtl/risc_v_defines.sv | 39 +++
 rtl/hazard_detect.sv | 39 +++
 rtl/if_id_hazard_unit.sv | 149 ++++++++++++++
 tb/tb_if_id_hazard_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_defines.sv
// Shared RISC-V core definitions: default widths, opcode constants, the
// canonical NOP encoding, the IF/ID stall FSM state type and helpers that
// classify which source registers an opcode actually reads.
package risc_v_defines;

  localparam int unsigned DEF_REG_WIDTH      = 32;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
  localparam int unsigned DEF_CNT_WIDTH      = 16;
  localparam int unsigned OPC_WIDTH          = 7;

  typedef logic [OPC_WIDTH-1:0] opcode_t;

  localparam opcode_t OPC_LOAD  = 7'b0000011;
  localparam opcode_t OPC_LUI   = 7'b0110111;
  localparam opcode_t OPC_AUIPC = 7'b0010111;
  localparam opcode_t OPC_JAL   = 7'b1101111;
  localparam opcode_t OPC_R     = 7'b0110011;
  localparam opcode_t OPC_S     = 7'b0100011;
  localparam opcode_t OPC_B     = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [DEF_REG_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [0:0] {
    StRun,
    StBubble
  } if_id_state_e;

  // U-type and JAL carry immediate bits in the rs1 field.
  function automatic logic rs1_used(input opcode_t opc);
    return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  endfunction

  // Only R, S and B formats encode a real rs2; elsewhere [24:20] is immediate.
  function automatic logic rs2_used(input opcode_t opc);
    return (opc == OPC_R) || (opc == OPC_S) || (opc == OPC_B);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   i_if_id_valid  - IF/ID holds a real instruction
//   i_id_ex_opcode - opcode of the instruction in ID/EX
//   i_id_ex_rd     - destination register of the instruction in ID/EX
//   i_if_id_opcode - opcode of the instruction in IF/ID
//   i_if_id_rs1    - rs1 field of the instruction in IF/ID
//   i_if_id_rs2    - rs2 field of the instruction in IF/ID
//   o_hazard       - ID/EX load produces a register IF/ID reads
module hazard_detect
  import risc_v_defines::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic                      i_if_id_valid,
  input  logic [OPC_WIDTH-1:0]      i_id_ex_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_ex_rd,
  input  logic [OPC_WIDTH-1:0]      i_if_id_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] i_if_id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_if_id_rs2,
  output logic                      o_hazard
);

  logic w_ex_is_load;
  logic w_rd_nonzero;
  logic w_rs1_match;
  logic w_rs2_match;

  assign w_ex_is_load = (i_id_ex_opcode == OPC_LOAD);
  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign w_rd_nonzero = (i_id_ex_rd != '0);
  // Only compare fields that the opcode really decodes as registers.
  assign w_rs1_match  = rs1_used(i_if_id_opcode) && (i_id_ex_rd == i_if_id_rs1);
  assign w_rs2_match  = rs2_used(i_if_id_opcode) && (i_id_ex_rd == i_if_id_rs2);

  assign o_hazard = i_if_id_valid && w_ex_is_load && w_rd_nonzero &&
                    (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/if_id_hazard_unit.sv
// IF/ID pipeline register with load-use stall and branch-flush control.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   pc_in, inst_in        - PC and instruction word from fetch
//   ID_EX_inst_opcode     - opcode currently in ID/EX
//   ID_EX_rd              - destination register currently in ID/EX
//   ID_EX_pc_sel          - branch/jump taken in EX (flush request)
//   IF_ID_pc, IF_ID_inst  - registered PC and instruction
//   IF_ID_inst_opcode/rd/rs1/rs2 - field slices of IF_ID_inst
//   IF_ID_valid           - IF/ID holds a real instruction
//   pc_write_en           - PC update enable (0 holds fetch during a stall)
//   ctr_sel               - 1 passes decode controls into ID/EX, 0 inserts a bubble
//   stall_cnt, flush_cnt  - saturating event counters
module if_id_hazard_unit
  import risc_v_defines::*;
#(
  parameter int unsigned REG_WIDTH      = DEF_REG_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [REG_WIDTH-1:0]      pc_in,
  input  logic [REG_WIDTH-1:0]      inst_in,
  input  logic [6:0]                ID_EX_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      ID_EX_pc_sel,
  output logic [REG_WIDTH-1:0]      IF_ID_pc,
  output logic [REG_WIDTH-1:0]      IF_ID_inst,
  output logic [6:0]                IF_ID_inst_opcode,
  output logic [REG_ADDR_WIDTH-1:0] IF_ID_rd,
  output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  output logic                      IF_ID_valid,
  output logic                      pc_write_en,
  output logic                      ctr_sel,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  if_id_state_e r_state;
  if_id_state_e w_state_next;

  logic [REG_WIDTH-1:0] r_pc;
  logic [REG_WIDTH-1:0] r_inst;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic w_hazard;
  logic w_hold;
  logic w_stall_evt;

  assign IF_ID_pc          = r_pc;
  assign IF_ID_inst        = r_inst;
  assign IF_ID_valid       = r_valid;
  assign IF_ID_inst_opcode = r_inst[6:0];
  assign IF_ID_rd          = r_inst[7 +: REG_ADDR_WIDTH];
  assign IF_ID_rs1         = r_inst[15 +: REG_ADDR_WIDTH];
  assign IF_ID_rs2         = r_inst[20 +: REG_ADDR_WIDTH];
  assign stall_cnt         = r_stall_cnt;
  assign flush_cnt         = r_flush_cnt;

  hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .i_if_id_valid  (r_valid),
    .i_id_ex_opcode (ID_EX_inst_opcode),
    .i_id_ex_rd     (ID_EX_rd),
    .i_if_id_opcode (IF_ID_inst_opcode),
    .i_if_id_rs1    (IF_ID_rs1),
    .i_if_id_rs2    (IF_ID_rs2),
    .o_hazard       (w_hazard)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: flush wins; BUBBLE always returns to RUN because ID/EX still
  // shows the stalled load and re-detecting would stall a second time.
  always_comb begin
    w_state_next = r_state;
    if (ID_EX_pc_sel) begin
      w_state_next = StRun;
    end else begin
      unique case (r_state)
        StRun:    if (w_hazard) w_state_next = StBubble;
        StBubble: w_state_next = StRun;
        default:  w_state_next = StRun;
      endcase
    end
  end

  // Outputs: flush squashes ID but lets the PC take the branch target.
  always_comb begin
    ctr_sel     = 1'b1;
    pc_write_en = 1'b1;
    w_hold      = 1'b0;
    w_stall_evt = 1'b0;
    if (ID_EX_pc_sel) begin
      ctr_sel = 1'b0;
    end else if ((r_state == StRun) && w_hazard) begin
      ctr_sel     = 1'b0;
      pc_write_en = 1'b0;
      w_hold      = 1'b1;
      w_stall_evt = 1'b1;
    end
  end

  // IF/ID register. On flush the PC is left as-is; only valid/inst matter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= '0;
      r_inst  <= REG_WIDTH'(NOP_INST);
      r_valid <= 1'b0;
    end else if (ID_EX_pc_sel) begin
      r_inst  <= REG_WIDTH'(NOP_INST);
      r_valid <= 1'b0;
    end else if (!w_hold) begin
      r_pc    <= pc_in;
      r_inst  <= inst_in;
      r_valid <= 1'b1;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CntOne;
      end
      if (ID_EX_pc_sel && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CntOne;
      end
    end
  end

endmodule

// File: tb/tb_if_id_hazard_unit.sv
module tb_if_id_hazard_unit;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] ADD_X5    = 32'h0072_8333; // add x6,x5,x7
  localparam logic [31:0] ADDI_X1   = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] LUI_X5    = 32'h0002_82B7; // lui x5,0x28 (rs1 field = 5)
  localparam logic [31:0] ADD_X0    = 32'h0070_0333; // add x6,x0,x7
  localparam logic [31:0] ADDI_IMM5 = 32'h0050_8313; // addi x6,x1,5 (rs2 field = 5)
  localparam logic [31:0] ADD_RS2   = 32'h0053_8333; // add x6,x7,x5
  localparam logic [31:0] LW_SELF   = 32'h0002_A283; // lw x5,0(x5)
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_R      = 7'b0110011;

  typedef struct {
    string       name;
    logic        cs;
    logic        we;
    logic [31:0] pc;
    logic        chk_pc;
    logic [31:0] inst;
    logic        valid;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic [6:0]  ID_EX_inst_opcode;
  logic [4:0]  ID_EX_rd;
  logic        ID_EX_pc_sel;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic [6:0]  IF_ID_inst_opcode;
  logic [4:0]  IF_ID_rd;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic        IF_ID_valid;
  logic        pc_write_en;
  logic        ctr_sel;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  if_id_hazard_unit dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pc_in             (pc_in),
    .inst_in           (inst_in),
    .ID_EX_inst_opcode (ID_EX_inst_opcode),
    .ID_EX_rd          (ID_EX_rd),
    .ID_EX_pc_sel      (ID_EX_pc_sel),
    .IF_ID_pc          (IF_ID_pc),
    .IF_ID_inst        (IF_ID_inst),
    .IF_ID_inst_opcode (IF_ID_inst_opcode),
    .IF_ID_rd          (IF_ID_rd),
    .IF_ID_rs1         (IF_ID_rs1),
    .IF_ID_rs2         (IF_ID_rs2),
    .IF_ID_valid       (IF_ID_valid),
    .pc_write_en       (pc_write_en),
    .ctr_sel           (ctr_sel),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string rec, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s.%s: got 0x%0h, want 0x%0h", rec, fld, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [6:0] op,
                       input logic [4:0] rd, input logic sel);
    pc_in             = pc;
    inst_in           = inst;
    ID_EX_inst_opcode = op;
    ID_EX_rd          = rd;
    ID_EX_pc_sel      = sel;
  endtask

  task automatic expect_now(input string nm, input logic cs, input logic we,
                            input logic [31:0] pc, input logic chk_pc, input logic [31:0] inst,
                            input logic valid, input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.name   = nm;
    e.cs     = cs;
    e.we     = we;
    e.pc     = pc;
    e.chk_pc = chk_pc;
    e.inst   = inst;
    e.valid  = valid;
    e.sc     = sc;
    e.fc     = fc;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.name, "ctr_sel", 32'(ctr_sel), 32'(e.cs));
        cmp(e.name, "pc_write_en", 32'(pc_write_en), 32'(e.we));
        if (e.chk_pc) cmp(e.name, "IF_ID_pc", IF_ID_pc, e.pc);
        cmp(e.name, "IF_ID_inst", IF_ID_inst, e.inst);
        cmp(e.name, "IF_ID_valid", 32'(IF_ID_valid), 32'(e.valid));
        cmp(e.name, "opcode", 32'(IF_ID_inst_opcode), 32'(e.inst[6:0]));
        cmp(e.name, "rd", 32'(IF_ID_rd), 32'(e.inst[11:7]));
        cmp(e.name, "rs1", 32'(IF_ID_rs1), 32'(e.inst[19:15]));
        cmp(e.name, "rs2", 32'(IF_ID_rs2), 32'(e.inst[24:20]));
        cmp(e.name, "stall_cnt", 32'(stall_cnt), 32'(e.sc));
        cmp(e.name, "flush_cnt", 32'(flush_cnt), 32'(e.fc));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    drive(32'h0, 32'h0, OP_IMM, 5'd0, 1'b0);
    expect_now("reset", 1, 1, 32'h0, 1, NOP, 0, 16'd0, 16'd0);

    tick(); reset_n = 1'b1;
    drive(32'h100, ADD_X5, OP_IMM, 5'd0, 1'b0);
    expect_now("post_reset", 1, 1, 32'h0, 1, NOP, 0, 16'd0, 16'd0);

    // Load-use on rs1: one bubble, PC held, then live
    tick(); drive(32'h104, ADDI_X1, OP_LOAD, 5'd5, 1'b0);
    expect_now("lu_rs1_stall", 0, 0, 32'h100, 1, ADD_X5, 1, 16'd0, 16'd0);
    tick(); drive(32'h104, ADDI_X1, OP_LOAD, 5'd5, 1'b0);
    expect_now("lu_rs1_bubble", 1, 1, 32'h100, 1, ADD_X5, 1, 16'd1, 16'd0);
    tick(); drive(32'h108, LUI_X5, OP_R, 5'd6, 1'b0);
    expect_now("lu_rs1_live", 1, 1, 32'h104, 1, ADDI_X1, 1, 16'd1, 16'd0);

    // No false hazards
    tick(); drive(32'h10C, ADD_X0, OP_LOAD, 5'd5, 1'b0);
    expect_now("lui_no_stall", 1, 1, 32'h108, 1, LUI_X5, 1, 16'd1, 16'd0);
    tick(); drive(32'h110, ADDI_IMM5, OP_LOAD, 5'd0, 1'b0);
    expect_now("rd0_no_stall", 1, 1, 32'h10C, 1, ADD_X0, 1, 16'd1, 16'd0);
    tick(); drive(32'h114, ADD_RS2, OP_LOAD, 5'd5, 1'b0);
    expect_now("itype_rs2_no_stall", 1, 1, 32'h110, 1, ADDI_IMM5, 1, 16'd1, 16'd0);

    // Load-use on rs2
    tick(); drive(32'h118, LW_SELF, OP_LOAD, 5'd5, 1'b0);
    expect_now("lu_rs2_stall", 0, 0, 32'h114, 1, ADD_RS2, 1, 16'd1, 16'd0);
    tick(); drive(32'h118, LW_SELF, OP_LOAD, 5'd5, 1'b0);
    expect_now("lu_rs2_bubble", 1, 1, 32'h114, 1, ADD_RS2, 1, 16'd2, 16'd0);

    // Load after load with self-dependency: one stall, not repeated in BUBBLE
    tick(); drive(32'h11C, ADDI_X1, OP_LOAD, 5'd5, 1'b0);
    expect_now("ll_stall", 0, 0, 32'h118, 1, LW_SELF, 1, 16'd2, 16'd0);
    tick(); drive(32'h11C, ADDI_X1, OP_LOAD, 5'd5, 1'b0);
    expect_now("ll_bubble", 1, 1, 32'h118, 1, LW_SELF, 1, 16'd3, 16'd0);
    tick(); drive(32'h120, ADD_X5, OP_LOAD, 5'd5, 1'b0);
    expect_now("ll_no_repeat", 1, 1, 32'h11C, 1, ADDI_X1, 1, 16'd3, 16'd0);

    // Flush coincident with a hazard
    tick(); drive(32'h124, ADDI_X1, OP_LOAD, 5'd5, 1'b1);
    expect_now("flush_hazard", 0, 1, 32'h120, 1, ADD_X5, 1, 16'd3, 16'd0);
    tick(); drive(32'h200, ADD_X5, OP_LOAD, 5'd5, 1'b0);
    expect_now("flush_after", 1, 1, 32'h0, 0, NOP, 0, 16'd3, 16'd1);

    // Reset asserted mid-stall, between clock edges
    tick(); drive(32'h204, ADDI_X1, OP_LOAD, 5'd5, 1'b0);
    expect_now("pre_reset_stall", 0, 0, 32'h200, 1, ADD_X5, 1, 16'd3, 16'd1);
    tick(); reset_n = 1'b0;
    expect_now("reset_mid_stall", 1, 1, 32'h0, 1, NOP, 0, 16'd0, 16'd0);
    tick(); reset_n = 1'b1;
    drive(32'h300, ADD_X5, OP_LOAD, 5'd5, 1'b0);
    expect_now("post_reset2", 1, 1, 32'h0, 1, NOP, 0, 16'd0, 16'd0);
    tick(); drive(32'h304, ADDI_X1, OP_LOAD, 5'd5, 1'b0);
    expect_now("no_stall_survives", 0, 0, 32'h300, 1, ADD_X5, 1, 16'd0, 16'd0);

    // Flush from BUBBLE, then hold flush until the counter saturates
    tick(); drive(32'h304, ADDI_X1, OP_IMM, 5'd0, 1'b1);
    expect_now("flush_in_bubble", 0, 1, 32'h300, 1, ADD_X5, 1, 16'd1, 16'd0);
    repeat (65540) tick();
    expect_now("flush_sat", 0, 1, 32'h0, 0, NOP, 0, 16'd1, 16'hFFFF);
    tick();
    expect_now("flush_no_wrap", 0, 1, 32'h0, 0, NOP, 0, 16'd1, 16'hFFFF);
    tick(); drive(32'h400, ADDI_X1, OP_IMM, 5'd0, 1'b0);
    expect_now("flush_release", 1, 1, 32'h0, 0, NOP, 0, 16'd1, 16'hFFFF);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
